fib_lpm_scheduler: RTL and testbench

//  Sequences the FIB's single hash unit and its valid-bit table (64 lengths x 1024 hashes) between two requesters.
//  - Insert requester: the data path learning prefixes.
//  - Lookup requester: PIT-out traffic needing a longest-prefix match.

---
 rtl/fib_pkg.sv | 25 ++
 rtl/fib_lpm_scheduler_if.sv | 42 ++++
 rtl/fib_rr_arb2.sv | 31 +++
 rtl/fib_lpm_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_fib_lpm_scheduler.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared widths, FSM state type and prefix-masking helper for the FIB LPM scheduler.
package fib_pkg;

    localparam int unsigned PREFIX_W = 64;
    localparam int unsigned LEN_W    = 6;
    localparam int unsigned HASH_W   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StHash,
        StWrite,
        StRead,
        StCheck,
        StResp
    } fib_lpm_state_e;

    // Keep the top len bits; len 0 yields all zeros.
    function automatic logic [PREFIX_W-1:0] fib_mask_prefix(input logic [PREFIX_W-1:0] prefix,
                                                            input logic [LEN_W-1:0]    len);
        logic [PREFIX_W-1:0] keep;
        keep = ~({PREFIX_W{1'b1}} >> len);
        return prefix & keep;
    endfunction

endpackage

// File: rtl/fib_lpm_scheduler_if.sv
// Request, result, hash-unit and valid-bit-table signals of the FIB LPM scheduler.
interface fib_lpm_scheduler_if;
    import fib_pkg::*;

    logic                ins_valid;
    logic                ins_ready;
    logic [PREFIX_W-1:0] ins_prefix;
    logic [LEN_W-1:0]    ins_len;
    logic                lkp_valid;
    logic                lkp_ready;
    logic [PREFIX_W-1:0] lkp_prefix;
    logic [LEN_W-1:0]    lkp_len;
    logic                res_valid;
    logic                res_ready;
    logic                res_hit;
    logic [PREFIX_W-1:0] res_prefix;
    logic [LEN_W-1:0]    res_len;
    logic [PREFIX_W-1:0] hash_prefix;
    logic [LEN_W-1:0]    hash_len;
    logic [HASH_W-1:0]   hash_value;
    logic                tbl_we;
    logic                tbl_re;
    logic [LEN_W-1:0]    tbl_len;
    logic [HASH_W-1:0]   tbl_hash;
    logic                tbl_rd_bit;
    logic                ins_done;

    modport slave (
        input  ins_valid, ins_prefix, ins_len, lkp_valid, lkp_prefix, lkp_len, res_ready,
               hash_value, tbl_rd_bit,
        output ins_ready, lkp_ready, res_valid, res_hit, res_prefix, res_len, hash_prefix,
               hash_len, tbl_we, tbl_re, tbl_len, tbl_hash, ins_done
    );

    modport master (
        output ins_valid, ins_prefix, ins_len, lkp_valid, lkp_prefix, lkp_len, res_ready,
               hash_value, tbl_rd_bit,
        input  ins_ready, lkp_ready, res_valid, res_hit, res_prefix, res_len, hash_prefix,
               hash_len, tbl_we, tbl_re, tbl_len, tbl_hash, ins_done
    );

endinterface

// File: rtl/fib_rr_arb2.sv
// Two-way round-robin arbiter; req/grant bit 0 is insert, bit 1 is lookup.
module fib_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_lkp_q, last_lkp_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_lkp_q ? 2'b01 : 2'b10;
        end
        last_lkp_d = last_lkp_q;
        if (advance) begin
            last_lkp_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_lkp_q <= 1'b0;
        end else begin
            last_lkp_q <= last_lkp_d;
        end
    end

endmodule

// File: rtl/fib_lpm_scheduler.sv
// Shares one hash unit and the valid-bit table between insert and LPM lookup requesters.
// Optional FIB_LPM_STATS_EN adds saturating lookup/hit/insert/probe counters.
module fib_lpm_scheduler
    import fib_pkg::*;
#(
    parameter int unsigned HASH_LAT   = 1,
    parameter int unsigned MAX_PROBES = 64
) (
    input logic                clk,
    input logic                rst,
    fib_lpm_scheduler_if.slave bus
`ifdef FIB_LPM_STATS_EN
    ,
    output logic [31:0]        stat_lookups,
    output logic [31:0]        stat_hits,
    output logic [31:0]        stat_inserts,
    output logic [31:0]        stat_probes
`endif
);

    localparam int unsigned WaitW  = $clog2(HASH_LAT + 1);
    localparam int unsigned ProbeW = $clog2(MAX_PROBES + 1);

    fib_lpm_state_e      state_q, state_d;
    logic                op_lkp_q, op_lkp_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [ProbeW-1:0]   probes_q, probes_d;
    logic                hit_q, hit_d;
    logic [1:0]          arb_grant;
    logic                arb_advance;
    logic [PREFIX_W-1:0] masked;

    assign masked = fib_mask_prefix(prefix_q, len_q);

    fib_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.lkp_valid, bus.ins_valid}),
        .advance (arb_advance),
        .grant   (arb_grant)
    );

    always_comb begin
        state_d         = state_q;
        op_lkp_d        = op_lkp_q;
        prefix_d        = prefix_q;
        len_d           = len_q;
        hash_d          = hash_q;
        wait_d          = wait_q;
        probes_d        = probes_q;
        hit_d           = hit_q;
        arb_advance     = 1'b0;
        bus.ins_ready   = 1'b0;
        bus.lkp_ready   = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_hit     = 1'b0;
        bus.res_prefix  = '0;
        bus.res_len     = '0;
        bus.hash_prefix = '0;
        bus.hash_len    = '0;
        bus.tbl_we      = 1'b0;
        bus.tbl_re      = 1'b0;
        bus.tbl_len     = '0;
        bus.tbl_hash    = '0;
        bus.ins_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.ins_ready = arb_grant[0];
                bus.lkp_ready = arb_grant[1];
                if (arb_grant != 2'b00) begin
                    arb_advance = 1'b1;
                    op_lkp_d    = arb_grant[1];
                    prefix_d    = arb_grant[1] ? bus.lkp_prefix : bus.ins_prefix;
                    len_d       = arb_grant[1] ? bus.lkp_len : bus.ins_len;
                    wait_d      = '0;
                    probes_d    = '0;
                    hit_d       = 1'b0;
                    state_d     = StHash;
                end
            end
            StHash: begin
                bus.hash_prefix = masked;
                bus.hash_len    = len_q;
                // Inputs held for HASH_LAT cycles, then the result is captured.
                if (wait_q == WaitW'(HASH_LAT)) begin
                    hash_d  = bus.hash_value;
                    wait_d  = '0;
                    state_d = op_lkp_q ? StRead : StWrite;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWrite: begin
                bus.tbl_we   = 1'b1;
                bus.tbl_len  = len_q;
                bus.tbl_hash = hash_q;
                bus.ins_done = 1'b1;
                state_d      = StIdle;
            end
            StRead: begin
                bus.tbl_re   = 1'b1;
                bus.tbl_len  = len_q;
                bus.tbl_hash = hash_q;
                state_d      = StCheck;
            end
            StCheck: begin
                if (bus.tbl_rd_bit) begin
                    hit_d   = 1'b1;
                    state_d = StResp;
                end else if (len_q == '0 || probes_q == ProbeW'(MAX_PROBES)) begin
                    hit_d   = 1'b0;
                    state_d = StResp;
                end else begin
                    len_d    = len_q - LEN_W'(1);
                    probes_d = probes_q + ProbeW'(1);
                    state_d  = StHash;
                end
            end
            StResp: begin
                bus.res_valid  = 1'b1;
                bus.res_hit    = hit_q;
                bus.res_len    = hit_q ? len_q : '0;
                bus.res_prefix = hit_q ? masked : '0;
                if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reset wins in the same cycle: no grant, write or result leaks out.
        if (rst) begin
            arb_advance     = 1'b0;
            bus.ins_ready   = 1'b0;
            bus.lkp_ready   = 1'b0;
            bus.res_valid   = 1'b0;
            bus.res_hit     = 1'b0;
            bus.res_prefix  = '0;
            bus.res_len     = '0;
            bus.hash_prefix = '0;
            bus.hash_len    = '0;
            bus.tbl_we      = 1'b0;
            bus.tbl_re      = 1'b0;
            bus.tbl_len     = '0;
            bus.tbl_hash    = '0;
            bus.ins_done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_lkp_q <= 1'b0;
            prefix_q <= '0;
            len_q    <= '0;
            hash_q   <= '0;
            wait_q   <= '0;
            probes_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_lkp_q <= op_lkp_d;
            prefix_q <= prefix_d;
            len_q    <= len_d;
            hash_q   <= hash_d;
            wait_q   <= wait_d;
            probes_q <= probes_d;
            hit_q    <= hit_d;
        end
    end

`ifdef FIB_LPM_STATS_EN
    logic [31:0] lookups_q, lookups_d, hits_q, hits_d;
    logic [31:0] inserts_q, inserts_d, probes_cnt_q, probes_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_comb begin
        lookups_d    = lookups_q;
        hits_d       = hits_q;
        inserts_d    = inserts_q;
        probes_cnt_d = probes_cnt_q;
        if (bus.lkp_valid && bus.lkp_ready) lookups_d = sat_inc(lookups_q);
        if (state_q == StCheck && bus.tbl_rd_bit) hits_d = sat_inc(hits_q);
        if (bus.tbl_we) inserts_d = sat_inc(inserts_q);
        if (bus.tbl_re) probes_cnt_d = sat_inc(probes_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q    <= '0;
            hits_q       <= '0;
            inserts_q    <= '0;
            probes_cnt_q <= '0;
        end else begin
            lookups_q    <= lookups_d;
            hits_q       <= hits_d;
            inserts_q    <= inserts_d;
            probes_cnt_q <= probes_cnt_d;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
    assign stat_inserts = inserts_q;
    assign stat_probes  = probes_cnt_q;
`endif

endmodule

// File: tb/tb_fib_lpm_scheduler.sv
// Directed bench for fib_lpm_scheduler with a registered hash model and valid-bit table model.
module tb_fib_lpm_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fib_lpm_scheduler_if bus ();
    fib_lpm_scheduler_if bus2 ();

`ifdef FIB_LPM_STATS_EN
    logic [31:0] s_lkp, s_hit, s_ins, s_prb, s2_lkp, s2_hit, s2_ins, s2_prb;
`endif

    fib_lpm_scheduler #(.HASH_LAT(1), .MAX_PROBES(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIB_LPM_STATS_EN
        ,
        .stat_lookups (s_lkp),
        .stat_hits    (s_hit),
        .stat_inserts (s_ins),
        .stat_probes  (s_prb)
`endif
    );

    fib_lpm_scheduler #(.HASH_LAT(1), .MAX_PROBES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
`ifdef FIB_LPM_STATS_EN
        ,
        .stat_lookups (s2_lkp),
        .stat_hits    (s2_hit),
        .stat_inserts (s2_ins),
        .stat_probes  (s2_prb)
`endif
    );

    function automatic logic [9:0] hfn(input logic [63:0] p, input logic [5:0] l);
        return p[63:54] ^ p[53:44] ^ p[9:0] ^ {4'd0, l};
    endfunction

    function automatic logic [63:0] tb_mask(input logic [63:0] p, input int l);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) if (i >= 64 - l) r[i] = p[i];
        return r;
    endfunction

    // One-cycle-latency hash unit, optionally forced to a fixed value.
    logic       ovr_en = 1'b0;
    logic [9:0] ovr_val = '0;
    logic [9:0] hv_q, hv2_q;
    always @(posedge clk) begin
        hv_q  <= ovr_en ? ovr_val : hfn(bus.hash_prefix, bus.hash_len);
        hv2_q <= hfn(bus2.hash_prefix, bus2.hash_len);
    end
    assign bus.hash_value  = hv_q;
    assign bus2.hash_value = hv2_q;
    assign bus2.tbl_rd_bit = 1'b0;

    logic       tbl_mem [64][1024];
    logic       tbl_clr = 1'b1;
    logic       pl_we = 1'b0;
    logic [5:0] pl_len = '0;
    logic [9:0] pl_hash = '0;
    always @(posedge clk) begin
        if (tbl_clr) begin
            for (int l = 0; l < 64; l++)
                for (int h = 0; h < 1024; h++) tbl_mem[l][h] <= 1'b0;
        end else begin
            if (pl_we) tbl_mem[pl_len][pl_hash] <= 1'b1;
            if (bus.tbl_we) tbl_mem[bus.tbl_len][bus.tbl_hash] <= 1'b1;
        end
        bus.tbl_rd_bit <= bus.tbl_re ? tbl_mem[bus.tbl_len][bus.tbl_hash] : 1'b0;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_table();
        tbl_clr = 1'b1;
        cyc();
        tbl_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ins_valid = 1'b1;
        bus.lkp_valid = 1'b1;
        cyc();
        cyc();
        #1;
        checks++;
        if ({bus.ins_ready, bus.lkp_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got %b want 00", {bus.ins_ready, bus.lkp_ready});
        end
        bus.ins_valid = 1'b0;
        bus.lkp_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        checks++;
        if ({bus.res_valid, bus.tbl_we, bus.tbl_re, bus.ins_done, bus.res_hit} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000",
                     {bus.res_valid, bus.tbl_we, bus.tbl_re, bus.ins_done, bus.res_hit});
        end
        checks++;
        if ({bus.hash_prefix, bus.hash_len, bus.tbl_len, bus.tbl_hash, bus.res_prefix,
             bus.res_len} !== '0) begin
            errors++;
            $display("FAIL reset_buses got %h/%h want 0", bus.hash_prefix, bus.hash_len);
        end
    endtask

    task automatic test_insert();
        int       done_at;
        int       pulses;
        logic     we;
        logic [5:0] tl;
        logic [9:0] th;
        done_at = -1;
        pulses  = 0;
        we = 1'b0; tl = '0; th = '0;
        ovr_en  = 1'b1;
        ovr_val = 10'h155;
        bus.ins_prefix = 64'hAB00_0000_0000_0000;
        bus.ins_len    = 6'd8;
        bus.ins_valid  = 1'b1;
        #1;
        checks++;
        if (bus.ins_ready !== 1'b1) begin
            errors++;
            $display("FAIL ins_ready got %b want 1", bus.ins_ready);
        end
        for (int n = 1; n <= 10; n++) begin
            cyc();
            bus.ins_valid = 1'b0;
            #1;
            if (n == 1) begin
                checks++;
                if ({bus.hash_prefix, bus.hash_len} !== {64'hAB00_0000_0000_0000, 6'd8}) begin
                    errors++;
                    $display("FAIL ins_hash_in got %h/%0d want ab00000000000000/8",
                             bus.hash_prefix, bus.hash_len);
                end
            end
            if (bus.ins_done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = n; we = bus.tbl_we; tl = bus.tbl_len; th = bus.tbl_hash;
                end
            end
        end
        checks++;
        if (done_at !== 3) begin
            errors++;
            $display("FAIL ins_latency got %0d want 3", done_at);
        end
        checks++;
        if ({we, tl, th} !== {1'b1, 6'd8, 10'h155}) begin
            errors++;
            $display("FAIL ins_write got we=%b len=%0d hash=%h want 1/8/155", we, tl, th);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ins_done_pulses got %0d want 1", pulses);
        end
        ovr_en = 1'b0;
    endtask

    task automatic run_lookup(input logic [63:0] p, input logic [5:0] l, output int reads,
                              output int first_len, output int last_len, output logic got);
        int n;
        reads = 0; first_len = -1; last_len = -1; got = 1'b0; n = 0;
        bus.res_ready  = 1'b0;
        bus.lkp_prefix = p;
        bus.lkp_len    = l;
        bus.lkp_valid  = 1'b1;
        #1;
        checks++;
        if (bus.lkp_ready !== 1'b1) begin
            errors++;
            $display("FAIL lkp_ready got %b want 1", bus.lkp_ready);
        end
        while (!got && n < 400) begin
            cyc();
            bus.lkp_valid = 1'b0;
            #1;
            n++;
            if (bus.tbl_re) begin
                reads++;
                if (reads == 1) first_len = int'(bus.tbl_len);
                last_len = int'(bus.tbl_len);
            end
            if (bus.res_valid) got = 1'b1;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL lkp_timeout got res_valid=%b want 1", got);
        end
    endtask

    task automatic test_lookup_hit();
        logic [63:0] p;
        int          reads, fl, ll;
        logic        got;
        p = 64'hDEAD_BEEF_0123_4567;
        pl_len  = 6'd16;
        pl_hash = hfn(tb_mask(p, 16), 6'd16);
        pl_we   = 1'b1;
        cyc();
        pl_we = 1'b0;
        run_lookup(p, 6'd24, reads, fl, ll, got);
        checks++;
        if ({reads, fl, ll} !== {32'd9, 32'd24, 32'd16}) begin
            errors++;
            $display("FAIL hit_probes got %0d reads lens %0d..%0d want 9 reads 24..16",
                     reads, fl, ll);
        end
        checks++;
        if ({bus.res_hit, bus.res_len, bus.res_prefix} !== {1'b1, 6'd16, 64'hDEAD_0000_0000_0000})
        begin
            errors++;
            $display("FAIL hit_result got %b/%0d/%h want 1/16/dead000000000000",
                     bus.res_hit, bus.res_len, bus.res_prefix);
        end
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hit_release got %b want 0", bus.res_valid);
        end
    endtask

    task automatic test_lookup_miss();
        int   reads, fl, ll, bad;
        logic got;
        bad = 0;
        clear_table();
        run_lookup(64'hFFFF_FFFF_FFFF_FFFF, 6'd3, reads, fl, ll, got);
        checks++;
        if ({reads, fl, ll} !== {32'd4, 32'd3, 32'd0}) begin
            errors++;
            $display("FAIL miss_probes got %0d reads lens %0d..%0d want 4 reads 3..0",
                     reads, fl, ll);
        end
        checks++;
        if ({bus.res_hit, bus.res_len, bus.res_prefix} !== '0) begin
            errors++;
            $display("FAIL miss_result got %b/%0d/%h want 0/0/0",
                     bus.res_hit, bus.res_len, bus.res_prefix);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            if (bus.res_valid !== 1'b1 || bus.res_len !== 6'd0 || bus.lkp_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL miss_hold got %0d unstable cycles want 0", bad);
        end
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int grants[4];
        int ng, busy, n;
        ng = 0; busy = 0; n = 0;
        clear_table();
        rst = 1'b1;
        bus.ins_prefix = 64'h1234_5678_9ABC_DEF0;
        bus.ins_len    = 6'd1;
        bus.lkp_prefix = 64'h8000_0000_0000_0000;
        bus.lkp_len    = 6'd0;
        bus.ins_valid  = 1'b1;
        bus.lkp_valid  = 1'b1;
        bus.res_ready  = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        while (ng < 4 && n < 100) begin
            #1;
            if ((bus.ins_ready || bus.lkp_ready) &&
                (bus.tbl_we || bus.tbl_re || bus.res_valid || bus.ins_done)) busy++;
            if (bus.ins_ready && bus.lkp_ready) busy++;
            if (bus.lkp_ready) begin grants[ng] = 1; ng++; end
            else if (bus.ins_ready) begin grants[ng] = 0; ng++; end
            cyc();
            n++;
        end
        bus.ins_valid = 1'b0;
        bus.lkp_valid = 1'b0;
        repeat (10) cyc();
        bus.res_ready = 1'b0;
        checks++;
        if (ng !== 4) begin
            errors++;
            $display("FAIL b2b_count got %0d grants want 4", ng);
        end else begin
            checks++;
            if ({grants[0], grants[1], grants[2], grants[3]} !== {32'd1, 32'd0, 32'd1, 32'd0})
            begin
                errors++;
                $display("FAIL b2b_order got %0d%0d%0d%0d want 1010 (1=LKP)",
                         grants[0], grants[1], grants[2], grants[3]);
            end
        end
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL b2b_busy_grant got %0d want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int   leaks, n;
        leaks = 0; n = 0;
        clear_table();
        ovr_en  = 1'b1;
        ovr_val = 10'h2AA;
        bus.ins_prefix = 64'hC000_0000_0000_0000;
        bus.ins_len    = 6'd2;
        bus.ins_valid  = 1'b1;
        cyc();
        bus.ins_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        if (bus.tbl_we || bus.ins_done) leaks++;
        cyc();
        #1;
        checks++;
        if ({bus.ins_ready, bus.lkp_ready, bus.res_valid, bus.tbl_we, bus.tbl_re, bus.ins_done,
             bus.hash_prefix, bus.hash_len, bus.tbl_len, bus.tbl_hash} !== '0) begin
            errors++;
            $display("FAIL abort_outputs got we=%b done=%b hp=%h want all 0",
                     bus.tbl_we, bus.ins_done, bus.hash_prefix);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            if (bus.tbl_we || bus.ins_done) leaks++;
        end
        checks++;
        if (leaks !== 0 || tbl_mem[2][10'h2AA] !== 1'b0) begin
            errors++;
            $display("FAIL abort_write got %0d leaks mem=%b want 0/0", leaks, tbl_mem[2][10'h2AA]);
        end
        ovr_en = 1'b0;
        bus.lkp_prefix = 64'h0F0F_0000_0000_0000;
        bus.lkp_len    = 6'd0;
        bus.lkp_valid  = 1'b1;
        bus.res_ready  = 1'b0;
        while (!bus.res_valid && n < 40) begin
            cyc();
            bus.lkp_valid = 1'b0;
            #1;
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_result got res_valid=%b want 0 (waited %0d)", bus.res_valid, n);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_max_probes();
        int   reads, n;
        logic got;
        reads = 0; n = 0; got = 1'b0;
        bus2.lkp_prefix = 64'h0123_4567_89AB_CDEF;
        bus2.lkp_len    = 6'd10;
        bus2.lkp_valid  = 1'b1;
        bus2.res_ready  = 1'b0;
        #1;
        checks++;
        if (bus2.lkp_ready !== 1'b1) begin
            errors++;
            $display("FAIL mp_ready got %b want 1", bus2.lkp_ready);
        end
        while (!got && n < 100) begin
            cyc();
            bus2.lkp_valid = 1'b0;
            #1;
            n++;
            if (bus2.tbl_re) reads++;
            if (bus2.res_valid) got = 1'b1;
        end
        checks++;
        if ({got, reads, bus2.res_hit, bus2.res_len} !== {1'b1, 32'd3, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL mp_miss got valid=%b reads=%0d hit=%b len=%0d want 1/3/0/0",
                     got, reads, bus2.res_hit, bus2.res_len);
        end
`ifdef FIB_LPM_STATS_EN
        checks++;
        if ({s2_prb, s2_lkp, s2_hit} !== {32'd3, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL mp_stats got %0d/%0d/%0d want 3/1/0", s2_prb, s2_lkp, s2_hit);
        end
`endif
        bus2.res_ready = 1'b1;
        cyc();
        bus2.res_ready = 1'b0;
    endtask

    initial begin
        bus.ins_valid = 1'b0; bus.ins_prefix = '0; bus.ins_len = '0;
        bus.lkp_valid = 1'b0; bus.lkp_prefix = '0; bus.lkp_len = '0;
        bus.res_ready = 1'b0;
        bus2.ins_valid = 1'b0; bus2.ins_prefix = '0; bus2.ins_len = '0;
        bus2.lkp_valid = 1'b0; bus2.lkp_prefix = '0; bus2.lkp_len = '0;
        bus2.res_ready = 1'b0;
        repeat (3) cyc();
        tbl_clr = 1'b0;
        test_reset();
        test_insert();
        test_lookup_hit();
        test_lookup_miss();
        test_back_to_back();
        test_reset_abort();
        test_max_probes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
